// File: rtl/reflet_float_add_seq.sv
// reflet_float_add_seq: multi-cycle floating-point adder/subtractor with an
// optional internal accumulator. Fixed pipeline of states
// IDLE -> ALIGN -> ADD -> NORM -> OUT.
// Subnormals are flushed to zero. Rounding is truncation toward zero.
module reflet_float_add_seq #(
    parameter int float_size = 32,
    parameter int exp_size   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    input  logic                  sub,
    input  logic                  acc_mode,
    input  logic                  acc_clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [float_size-1:0] sum,
    output logic                  overflow,
    output logic                  invalid
);
    localparam int mant_size = float_size - 1 - exp_size;
    // Significand with hidden bit, mantissa and guard/round/sticky bits.
    localparam int sig_w     = mant_size + 4;

    typedef enum logic [2:0] {
        st_idle, st_align, st_add, st_norm, st_out
    } state_t;

    state_t state_reg, state_next;
    logic   alive_reg;

    logic [float_size-1:0] op_a_reg, op_b_reg, acc_reg;
    logic                  sub_reg, accm_reg;

    logic                  al_sign_reg, al_esub_reg;
    logic                  al_nan_reg, al_inf_reg, al_inf_sign_reg;
    logic [exp_size-1:0]   al_exp_reg;
    logic [sig_w-1:0]      al_big_reg, al_small_reg;
    logic [sig_w:0]        ad_sig_reg;

    logic [float_size-1:0] sum_reg;
    logic                  overflow_reg, invalid_reg;

    logic accept;
    assign in_ready  = alive_reg && (state_reg == st_idle);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == st_out);
    assign sum       = sum_reg;
    assign overflow  = overflow_reg;
    assign invalid   = invalid_reg;

    // ---------------- ALIGN stage combinational logic ----------------
    logic                   sa, sb, swap;
    logic [exp_size-1:0]    ea, eb, big_exp, small_exp, diff;
    logic [mant_size-1:0]   ma, mb;
    logic                   a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic [float_size-2:0]  mag_a, mag_b;
    logic [sig_w-1:0]       sig_a, sig_b, big_sig, small_sig, small_shr, shift_mask;
    logic                   sticky;

    assign sa = op_a_reg[float_size-1];
    assign sb = op_b_reg[float_size-1] ^ sub_reg;
    assign ea = op_a_reg[float_size-2:mant_size];
    assign eb = op_b_reg[float_size-2:mant_size];
    assign ma = op_a_reg[mant_size-1:0];
    assign mb = op_b_reg[mant_size-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (ea == '1) && (ma != '0);
    assign b_nan  = (eb == '1) && (mb != '0);
    assign a_inf  = (ea == '1) && (ma == '0);
    assign b_inf  = (eb == '1) && (mb == '0);

    // Magnitudes compare as unsigned integers once subnormals are flushed.
    assign mag_a = a_zero ? '0 : op_a_reg[float_size-2:0];
    assign mag_b = b_zero ? '0 : op_b_reg[float_size-2:0];
    assign swap  = (mag_b > mag_a);

    assign sig_a = a_zero ? '0 : {1'b1, ma, 3'b000};
    assign sig_b = b_zero ? '0 : {1'b1, mb, 3'b000};

    assign big_sig   = swap ? sig_b : sig_a;
    assign small_sig = swap ? sig_a : sig_b;
    assign big_exp   = swap ? eb : ea;
    assign small_exp = swap ? ea : eb;
    assign diff      = big_exp - small_exp;

    // Mask of bits lost by the alignment shift; saturates to all ones when
    // the difference exceeds the significand width, leaving only sticky.
    for (genvar gi = 0; gi < sig_w; gi++) begin : g_mask
        assign shift_mask[gi] = (int'(diff) > gi);
    end

    assign small_shr = small_sig >> diff;
    assign sticky    = |(small_sig & shift_mask);

    // ---------------- NORM stage combinational logic ----------------
    int                     lz, exp_i;
    logic [mant_size-1:0]   norm_mant;
    logic [float_size-1:0]  norm_sum;
    logic                   norm_ovf, norm_inv;

    // Leading-one detect, normalise, then apply special cases in priority order.
    always_comb begin
        lz = 0;
        for (int i = 0; i < sig_w; i++) begin
            if (ad_sig_reg[i]) lz = sig_w - 1 - i;
        end
        if (ad_sig_reg[sig_w]) begin
            exp_i     = int'(al_exp_reg) + 1;
            norm_mant = ad_sig_reg[sig_w-1:4];
        end else begin
            exp_i     = int'(al_exp_reg) - lz;
            norm_mant = mant_size'((ad_sig_reg[sig_w-1:0] << lz) >> 3);
        end
        norm_ovf = 1'b0;
        norm_inv = 1'b0;
        if (al_nan_reg) begin
            norm_sum = {1'b0, {exp_size{1'b1}}, 1'b1, {(mant_size-1){1'b0}}};
            norm_inv = 1'b1;
        end else if (al_inf_reg) begin
            norm_sum = {al_inf_sign_reg, {exp_size{1'b1}}, {mant_size{1'b0}}};
        end else if (ad_sig_reg == '0) begin
            norm_sum = '0;
        end else if (exp_i >= (1 << exp_size) - 1) begin
            norm_sum = {al_sign_reg, {exp_size{1'b1}}, {mant_size{1'b0}}};
            norm_ovf = 1'b1;
        end else if (exp_i <= 0) begin
            norm_sum = {al_sign_reg, {(float_size-1){1'b0}}};
        end else begin
            norm_sum = {al_sign_reg, exp_i[exp_size-1:0], norm_mant};
        end
    end

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= st_idle;
        else        state_reg <= state_next;
    end

    // Next-state logic: fixed walk through the stages, OUT waits for the consumer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            st_idle:  if (accept) state_next = st_align;
            st_align: state_next = st_add;
            st_add:   state_next = st_norm;
            st_norm:  state_next = st_out;
            st_out:   if (out_ready) state_next = st_idle;
            default:  state_next = st_idle;
        endcase
    end

    // Datapath: operand latch, stage registers, result and accumulator update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_reg       <= 1'b0;
            op_a_reg        <= '0;
            op_b_reg        <= '0;
            acc_reg         <= '0;
            sub_reg         <= 1'b0;
            accm_reg        <= 1'b0;
            al_sign_reg     <= 1'b0;
            al_esub_reg     <= 1'b0;
            al_nan_reg      <= 1'b0;
            al_inf_reg      <= 1'b0;
            al_inf_sign_reg <= 1'b0;
            al_exp_reg      <= '0;
            al_big_reg      <= '0;
            al_small_reg    <= '0;
            ad_sig_reg      <= '0;
            sum_reg         <= '0;
            overflow_reg    <= 1'b0;
            invalid_reg     <= 1'b0;
        end else begin
            alive_reg <= 1'b1;
            case (state_reg)
                st_idle: begin
                    if (acc_clear) acc_reg <= '0;
                    if (accept) begin
                        // A coincident clear means the accumulate sees +0.
                        op_a_reg     <= acc_mode ? (acc_clear ? '0 : acc_reg) : in1;
                        op_b_reg     <= in2;
                        sub_reg      <= sub;
                        accm_reg     <= acc_mode;
                        overflow_reg <= 1'b0;
                        invalid_reg  <= 1'b0;
                    end
                end
                st_align: begin
                    al_sign_reg     <= swap ? sb : sa;
                    al_esub_reg     <= (sa != sb);
                    al_exp_reg      <= big_exp;
                    al_big_reg      <= big_sig;
                    al_small_reg    <= {small_shr[sig_w-1:1], small_shr[0] | sticky};
                    al_nan_reg      <= a_nan || b_nan || (a_inf && b_inf && (sa != sb));
                    al_inf_reg      <= a_inf || b_inf;
                    al_inf_sign_reg <= a_inf ? sa : sb;
                end
                st_add: begin
                    ad_sig_reg <= al_esub_reg ? ({1'b0, al_big_reg} - {1'b0, al_small_reg})
                                              : ({1'b0, al_big_reg} + {1'b0, al_small_reg});
                end
                st_norm: begin
                    sum_reg      <= norm_sum;
                    overflow_reg <= norm_ovf;
                    invalid_reg  <= norm_inv;
                end
                st_out: begin
                    if (out_ready && accm_reg) acc_reg <= sum_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_float_add_seq.sv
// Directed bench for reflet_float_add_seq: a vector table for both a 32-bit
// and a 16-bit instance, plus hand sequences for accumulator clear,
// backpressure and reset during an operation.
module tb_reflet_float_add_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        iv32, ir32, s32, am32, ac32, ov32, or32, of32, inv32;
    logic [31:0] a32, b32, sum32;
    logic        iv16, ir16, s16, am16, ac16, ov16, or16, of16, inv16;
    logic [15:0] a16, b16, sum16;

    int n_cmp = 0;
    int n_bad = 0;

    reflet_float_add_seq dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .in1(a32), .in2(b32), .sub(s32), .acc_mode(am32), .acc_clear(ac32),
        .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .overflow(of32), .invalid(inv32)
    );

    reflet_float_add_seq #(.float_size(16), .exp_size(5)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
        .in1(a16), .in2(b16), .sub(s16), .acc_mode(am16), .acc_clear(ac16),
        .out_valid(ov16), .out_ready(or16), .sum(sum16),
        .overflow(of16), .invalid(inv16)
    );

    typedef struct {
        bit          w16;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        am;
        logic        ac;
        logic [31:0] exp_sum;
        logic        exp_ovf;
        logic        exp_inv;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    // One full transaction with out_ready held high; lat counts rising edges
    // from the accept edge (counted as 1) to the first edge after which
    // out_valid is seen high.
    task automatic run_op(input bit w16, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic am, input logic ac,
                          output logic [31:0] res, output logic ovf, output logic inv,
                          output int lat);
        int n;
        @(negedge clk);
        if (w16) begin
            a16 = a[15:0]; b16 = b[15:0]; s16 = s; am16 = am; ac16 = ac;
            or16 = 1'b1; iv16 = 1'b1;
        end else begin
            a32 = a; b32 = b; s32 = s; am32 = am; ac32 = ac;
            or32 = 1'b1; iv32 = 1'b1;
        end
        n = 0;
        while (!(w16 ? ir16 : ir32) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0; ac16 = 1'b0; iv32 = 1'b0; ac32 = 1'b0;
        lat = 1;
        while (!(w16 ? ov16 : ov32) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = w16 ? {16'h0000, sum16} : sum32;
        ovf = w16 ? of16 : of32;
        inv = w16 ? inv16 : inv32;
    endtask

    initial begin
        logic [31:0] res;
        logic        ovf, inv, saw_valid;
        int          lat, n;

        reset = 1'b0;
        iv32 = 0; s32 = 0; am32 = 0; ac32 = 0; or32 = 0; a32 = '0; b32 = '0;
        iv16 = 0; s16 = 0; am16 = 0; ac16 = 0; or16 = 0; a16 = '0; b16 = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, ir32}, 32'd0);
        check("rst_in_ready16", {31'b0, ir16}, 32'd0);
        check("rst_out_valid", {31'b0, ov32}, 32'd0);
        check("rst_sum", sum32, 32'h0);
        check("rst_overflow", {31'b0, of32}, 32'd0);
        check("rst_invalid", {31'b0, inv32}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, ir32}, 32'd1);

        // ---- vector table ----
        vecs.push_back('{0, 32'h40A00000, 32'h41700000, 0, 0, 0, 32'h41A00000, 0, 0});
        vecs.push_back('{0, 32'h3F800000, 32'h3F800000, 1, 0, 0, 32'h00000000, 0, 0});
        vecs.push_back('{0, 32'h3F800000, 32'h40000000, 1, 0, 0, 32'hBF800000, 0, 0});
        vecs.push_back('{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0, 0, 32'h7F800000, 1, 0});
        vecs.push_back('{0, 32'h7F800000, 32'h7F800000, 1, 0, 0, 32'h7FC00000, 0, 1});
        vecs.push_back('{0, 32'h7F800001, 32'h3F800000, 0, 0, 0, 32'h7FC00000, 0, 1});
        vecs.push_back('{0, 32'hFF800000, 32'h3F800000, 0, 0, 0, 32'hFF800000, 0, 0});
        vecs.push_back('{0, 32'h3F800000, 32'h7F800000, 1, 0, 0, 32'hFF800000, 0, 0});
        vecs.push_back('{0, 32'h4B800000, 32'h3F800000, 0, 0, 0, 32'h4B800000, 0, 0});
        vecs.push_back('{0, 32'h3F800000, 32'h33800000, 1, 0, 0, 32'h3F7FFFFF, 0, 0});
        vecs.push_back('{0, 32'h3F800000, 32'h30800000, 1, 0, 0, 32'h3F7FFFFF, 0, 0});
        vecs.push_back('{0, 32'h00400000, 32'h00400000, 0, 0, 0, 32'h00000000, 0, 0});
        vecs.push_back('{0, 32'h80800001, 32'h80800000, 1, 0, 0, 32'h80000000, 0, 0});
        vecs.push_back('{0, 32'hBF800000, 32'h3F800000, 0, 0, 0, 32'h00000000, 0, 0});
        vecs.push_back('{0, 32'h42000000, 32'h3F800000, 0, 1, 1, 32'h3F800000, 0, 0});
        vecs.push_back('{0, 32'h42000000, 32'h3F800000, 0, 1, 0, 32'h40000000, 0, 0});
        vecs.push_back('{0, 32'h42000000, 32'h3F800000, 0, 1, 0, 32'h40400000, 0, 0});
        vecs.push_back('{0, 32'h42000000, 32'h3F800000, 0, 1, 1, 32'h3F800000, 0, 0});
        vecs.push_back('{1, 32'h00003C00, 32'h00003C00, 0, 0, 0, 32'h00004000, 0, 0});
        vecs.push_back('{1, 32'h00007BFF, 32'h00007BFF, 0, 0, 0, 32'h00007C00, 1, 0});

        foreach (vecs[i]) begin
            run_op(vecs[i].w16, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].am, vecs[i].ac,
                   res, ovf, inv, lat);
            $display("vec %0d: w16=%0d %h %s %h acc=%0d clr=%0d -> %h ovf=%b inv=%b lat=%0d",
                     i, vecs[i].w16, vecs[i].a, vecs[i].s ? "-" : "+", vecs[i].b,
                     vecs[i].am, vecs[i].ac, res, ovf, inv, lat);
            check($sformatf("vec%0d_sum", i), res, vecs[i].exp_sum);
            check($sformatf("vec%0d_overflow", i), {31'b0, ovf}, {31'b0, vecs[i].exp_ovf});
            check($sformatf("vec%0d_invalid", i), {31'b0, inv}, {31'b0, vecs[i].exp_inv});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
        end

        // ---- standalone acc_clear pulse in IDLE (accumulator holds 1.0 here) ----
        @(negedge clk);
        ac32 = 1'b1;
        @(negedge clk);
        ac32 = 1'b0;
        run_op(0, 32'h42000000, 32'h40000000, 0, 1, 0, res, ovf, inv, lat);
        $display("acc after clear pulse: +2.0 -> %h lat=%0d", res, lat);
        check("clear_pulse_sum", res, 32'h40000000);

        // ---- backpressure: out_ready low for 10 cycles, new request pending ----
        @(negedge clk);
        a32 = 32'h3F800000; b32 = 32'h3F800000; s32 = 0; am32 = 0; ac32 = 0;
        or32 = 1'b0; iv32 = 1'b1;
        n = 0;
        while (!ir32 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        a32 = 32'h40400000; b32 = 32'h40400000;
        n = 0;
        while (!ov32 && n < 20) begin @(negedge clk); n++; end
        check("bp_first_sum", sum32, 32'h40000000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("bp_sum_c%0d", k), sum32, 32'h40000000);
            check($sformatf("bp_out_valid_c%0d", k), {31'b0, ov32}, 32'd1);
            check($sformatf("bp_in_ready_c%0d", k), {31'b0, ir32}, 32'd0);
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        @(negedge clk);
        $display("backpressure release: sum=%h out_valid=%b in_ready=%b", sum32, ov32, ir32);
        check("bp_after_out_valid", {31'b0, ov32}, 32'd0);
        check("bp_after_in_ready", {31'b0, ir32}, 32'd1);
        check("bp_after_sum_held", sum32, 32'h40000000);

        // ---- reset while in ALIGN (accumulator holds 2.0 here) ----
        @(negedge clk);
        a32 = 32'h0; b32 = 32'h3F800000; s32 = 0; am32 = 1; ac32 = 0;
        or32 = 1'b1; iv32 = 1'b1;
        n = 0;
        while (!ir32 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_in_ready", {31'b0, ir32}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            saw_valid = saw_valid | ov32;
        end
        $display("reset in ALIGN: out_valid seen=%b sum=%h", saw_valid, sum32);
        check("midrst_no_out_valid", {31'b0, saw_valid}, 32'd0);
        check("midrst_sum", sum32, 32'h0);
        run_op(0, 32'h42000000, 32'h3F800000, 0, 1, 0, res, ovf, inv, lat);
        $display("acc after reset: +1.0 -> %h lat=%0d", res, lat);
        check("midrst_acc_zero", res, 32'h3F800000);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reflet_float_add_seq.md
Name: reflet_float_add_seq

Overview:
- Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor with an optional accumulate mode.
- Successor to the combinational reflet_float_add. It adds a configurable format width, valid/ready handshakes on both sides, exception flags and an internal accumulator register.
- Sits between the int/float converters and the FPU result bus.

Parameters:
- float_size, 32, total width of a float word.
- exp_size, 8, exponent width. Mantissa width = float_size-1-exp_size. Bias = 2^(exp_size-1)-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- in1  in  float_size  first operand. Ignored when acc_mode=1.
- in2  in  float_size  second operand.
- sub  in  1  1: compute first - in2. 0: compute first + in2.
- acc_mode  in  1  1: first operand is the accumulator; the result is written back to the accumulator.
- acc_clear  in  1  sets the accumulator to +0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- sum  out  float_size  result.
- overflow  out  1  result overflowed to infinity.
- invalid  out  1  result is NaN.

Behaviour:
- Reset state: in_ready=0 during reset, 1 after reset deasserts. out_valid=0, sum=0, overflow=0, invalid=0, accumulator=+0, FSM=IDLE.
- Reset mid-operation aborts the operation immediately. No result is emitted.
- FSM transitions:
  - IDLE -> ALIGN on in_valid&in_ready. Operands, sub and acc_mode are latched.
  - ALIGN -> ADD -> NORM -> OUT unconditionally.
  - OUT -> IDLE on out_ready.
- in_ready=1 only in IDLE. Latency is exactly 4 cycles from the accept edge to out_valid=1. Maximum throughput is one operation per 5 cycles.
- out_valid=1 only in OUT. sum and flags hold stable until the out_ready handshake. They keep their last value after the handshake.
- ALIGN stage:
  - Unpack both operands.
  - Exponent field 0 means zero: flush subnormals to zero.
  - Effective sign of the second operand = sign(in2) XOR sub.
  - Swap operands so the larger magnitude comes first.
  - Right-shift the smaller significand by the exponent difference in a single barrel shift. Keep 3 extra bits (guard/round/sticky). A difference greater than mant+3 yields sticky only.
- ADD stage: add or subtract the significands according to the signs. Result sign = sign of the larger-magnitude operand.
- NORM stage:
  - Leading-one detect, left shift, exponent adjust; a carry-out right-shifts by 1.
  - Rounding = truncation (toward zero). Extra bits are discarded.
- Special cases, in priority order:
  1. Either operand is NaN (exp all-ones, mant≠0), or inf - inf (effective subtraction of equal infinities): sum = canonical NaN (sign 0, exp all-ones, mant MSB 1, rest 0); invalid=1.
  2. Either operand is infinite: sum = that infinity, with the effective sign applied.
  3. Exact zero result: sum = +0.
  4. Exponent ≥ all-ones after normalisation: sum = signed infinity; overflow=1.
  5. Exponent ≤ 0 after normalisation: sum = signed zero. No flag.
- Flags are cleared on every accepted operation and set only by that operation.
- Accumulate mode:
  - When acc_mode=1, the accumulator replaces in1.
  - On the OUT handshake, accumulator ← sum. This applies to any accepted operation with acc_mode=1 only.
- acc_clear:
  - Acts only in IDLE.
  - If it coincides with an accepted acc_mode=1 request, the clear applies first, so the operation sees +0.
  - acc_clear outside IDLE is ignored.
- Back-to-back requests while busy are not accepted; in_valid must hold until in_ready.

Test Plan:
- Default parameters: in1=0x40A00000 (5.0), in2=0x41700000 (15.0), sub=0 -> sum=0x41A00000 (20.0) with out_valid exactly 4 cycles after accept; flags 0.
- Subtraction and zero: in1=in2=0x3F800000, sub=1 -> sum=0x00000000. Then in1=0x3F800000, in2=0x40000000, sub=1 -> 0xBF800000.
- Exceptions: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow=1. 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1. NaN input 0x7F800001 + 1.0 -> 0x7FC00000, invalid=1.
- Accumulate: pulse acc_clear, then three acc_mode=1 adds of in2=0x3F800000 -> sums 0x3F800000, 0x40000000, 0x40400000. acc_clear coinciding with the fourth request -> 0x3F800000.
- Backpressure/reset: hold out_ready=0 for 10 cycles -> sum stable, in_ready=0, new in_valid not accepted. Assert reset in ALIGN -> out_valid never rises, accumulator=+0.
- float_size=16, exp_size=5: 0x3C00+0x3C00 -> 0x4000. 0x7BFF+0x7BFF -> 0x7C00, overflow=1.
